// File: rtl/display_arbiter_pkg.sv
// Shared encodings and defaults for the two-requester seven-segment display arbiter.
package display_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam int DWELL_DEFAULT = 50_000_000;
  localparam int TW_DEFAULT    = 26;

endpackage

// File: rtl/display_arbiter_dwell_timer.sv
// Saturating up-counter with clear and enable; flags the final dwell cycle (DWELL-1).
module dwell_timer #(
  parameter int DWELL = 50_000_000,
  parameter int TW    = 26
) (
  input  logic SysClk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TW-1:0] cnt;

  assign tc = (cnt == TW'(DWELL - 1));

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge SysClk) begin
    if (Reset)           cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !tc)  cnt <= cnt + TW'(1);
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin request/grant arbiter with minimum dwell time that muxes one of two
// digit/decimal-point words onto the 4x7 segment controller inputs.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT,
  parameter int TW    = TW_DEFAULT
) (
  input  logic        SysClk,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic        ReqB,
  input  logic [15:0] DigitsA,
  input  logic [15:0] DigitsB,
  input  logic [3:0]  DpA,
  input  logic [3:0]  DpB,
  output logic        GntA,
  output logic        GntB,
  output logic [3:0]  Digit1,
  output logic [3:0]  Digit2,
  output logic [3:0]  Digit3,
  output logic [3:0]  Digit4,
  output logic        Dp0,
  output logic        Dp1,
  output logic        Dp2,
  output logic        Dp3
);

  state_t        state, next_state;
  req_id_t       last;
  logic          tc;
  logic          timer_clr, timer_en;
  logic [15:0]   digits_q;
  logic [3:0]    dp_q;

  always_ff @(posedge SysClk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state defaults to state first, so no path through the case leaves it unassigned.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ReqA && ReqB) next_state = (last == REQ_B) ? OWN_A : OWN_B;
        else if (ReqA)    next_state = OWN_A;
        else if (ReqB)    next_state = OWN_B;
      end
      OWN_A: begin
        if (!ReqA)          next_state = ReqB ? OWN_B : IDLE;
        else if (ReqB && tc) next_state = OWN_B;
      end
      OWN_B: begin
        if (!ReqB)          next_state = ReqA ? OWN_A : IDLE;
        else if (ReqA && tc) next_state = OWN_A;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    GntA = (state == OWN_A);
    GntB = (state == OWN_B);
  end

  // Any entry into an ownership state (including a direct handover) restarts the dwell.
  assign timer_clr = (next_state != IDLE) && (next_state != state);
  assign timer_en  = (next_state != IDLE) && (next_state == state);

  dwell_timer #(
    .DWELL (DWELL),
    .TW    (TW)
  ) u_dwell_timer (
    .SysClk (SysClk),
    .Reset  (Reset),
    .clr    (timer_clr),
    .en     (timer_en),
    .tc     (tc)
  );

  always_ff @(posedge SysClk) begin
    if (Reset)                                       last <= REQ_B;
    else if (next_state == OWN_A && state != OWN_A)  last <= REQ_A;
    else if (next_state == OWN_B && state != OWN_B)  last <= REQ_B;
  end

  // The display follows the current owner live and freezes while nobody owns it.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      digits_q <= '0;
      dp_q     <= '0;
    end else begin
      case (state)
        OWN_A: begin
          digits_q <= DigitsA;
          dp_q     <= DpA;
        end
        OWN_B: begin
          digits_q <= DigitsB;
          dp_q     <= DpB;
        end
        default: ;
      endcase
    end
  end

  assign Digit1 = digits_q[15:12];
  assign Digit2 = digits_q[11:8];
  assign Digit3 = digits_q[7:4];
  assign Digit4 = digits_q[3:0];
  assign Dp0    = dp_q[0];
  assign Dp1    = dp_q[1];
  assign Dp2    = dp_q[2];
  assign Dp3    = dp_q[3];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed and randomized checks of display_arbiter against an ownership-history model.
module tb_display_arbiter;

  localparam int DWELL = 4;
  localparam int TW    = 3;

  logic        SysClk = 1'b0;
  logic        Reset  = 1'b0;
  logic        ReqA   = 1'b0;
  logic        ReqB   = 1'b0;
  logic [15:0] DigitsA = '0;
  logic [15:0] DigitsB = '0;
  logic [3:0]  DpA = '0;
  logic [3:0]  DpB = '0;
  logic        GntA, GntB;
  logic [3:0]  Digit1, Digit2, Digit3, Digit4;
  logic        Dp0, Dp1, Dp2, Dp3;

  display_arbiter #(
    .DWELL (DWELL),
    .TW    (TW)
  ) dut (
    .SysClk  (SysClk),
    .Reset   (Reset),
    .ReqA    (ReqA),
    .ReqB    (ReqB),
    .DigitsA (DigitsA),
    .DigitsB (DigitsB),
    .DpA     (DpA),
    .DpB     (DpB),
    .GntA    (GntA),
    .GntB    (GntB),
    .Digit1  (Digit1),
    .Digit2  (Digit2),
    .Digit3  (Digit3),
    .Digit4  (Digit4),
    .Dp0     (Dp0),
    .Dp1     (Dp1),
    .Dp2     (Dp2),
    .Dp3     (Dp3)
  );

  always #5 SysClk = ~SysClk;

  int tests = 0;
  int fails = 0;

  // Model: owner 0=none 1=A 2=B; held = edges spent owning since the grant.
  int          m_owner = 0;
  int          m_held  = 0;
  int          m_last  = 2;
  logic [15:0] m_dig   = '0;
  logic [3:0]  m_dp    = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] disp_word();
    return {Digit1, Digit2, Digit3, Digit4};
  endfunction

  function automatic logic [3:0] disp_dp();
    return {Dp3, Dp2, Dp1, Dp0};
  endfunction

  task automatic model_edge();
    int nxt;
    bit rx, ry;
    if (Reset) begin
      m_owner = 0; m_held = 0; m_last = 2; m_dig = '0; m_dp = '0;
      return;
    end
    if (m_owner == 1) begin m_dig = DigitsA; m_dp = DpA; end
    if (m_owner == 2) begin m_dig = DigitsB; m_dp = DpB; end
    if (m_owner == 0) begin
      if (ReqA && ReqB) nxt = (m_last == 1) ? 2 : 1;
      else if (ReqA)    nxt = 1;
      else if (ReqB)    nxt = 2;
      else              nxt = 0;
    end else begin
      rx = (m_owner == 1) ? ReqA : ReqB;
      ry = (m_owner == 1) ? ReqB : ReqA;
      if (!rx)                          nxt = ry ? 3 - m_owner : 0;
      else if (ry && m_held >= DWELL-1) nxt = 3 - m_owner;
      else                              nxt = m_owner;
    end
    if (nxt != 0 && nxt != m_owner) begin
      m_held = 0;
      m_last = nxt;
    end else if (nxt != 0) begin
      m_held++;
    end
    m_owner = nxt;
  endtask

  task automatic compare_model();
    check("gnt_a", 16'(GntA), 16'(m_owner == 1));
    check("gnt_b", 16'(GntB), 16'(m_owner == 2));
    check("digits", disp_word(), m_dig);
    check("dp", 16'(disp_dp()), 16'(m_dp));
  endtask

  task automatic step();
    @(posedge SysClk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with both requests high.
    Reset = 1'b1; ReqA = 1'b1; ReqB = 1'b1;
    step(); step();
    check("rst_gnt", 16'({GntA, GntB}), 16'h0);
    check("rst_digits", disp_word(), 16'h0000);
    check("rst_dp", 16'(disp_dp()), 16'h0);

    // Single owner; display one edge behind grant and tracks live data.
    Reset = 1'b0; ReqB = 1'b0; ReqA = 1'b1;
    DigitsA = 16'h1234; DpA = 4'b0010;
    step();
    check("a_grant_edge1", 16'(GntA), 16'h1);
    step();
    check("a_digits_edge2", disp_word(), 16'h1234);
    check("a_dp_edge2", 16'(disp_dp()), 16'h2);
    DigitsA = 16'h5678;
    step();
    check("a_live_update", disp_word(), 16'h5678);

    // Continuous contention: A A A A B B B B A A A A.
    do_reset();
    ReqA = 1'b1; ReqB = 1'b1; DigitsB = 16'hABCD; DpB = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      step();
      check("rr_owner", 16'({GntA, GntB}), ((i / 4) % 2 == 0) ? 16'h2 : 16'h1);
    end

    // Release to IDLE holds the display; a later request is granted next edge.
    do_reset();
    ReqA = 1'b1; ReqB = 1'b0; DigitsA = 16'hBEEF; DpA = 4'b0000;
    step(); step();
    ReqA = 1'b0;
    step();
    check("release_gnt", 16'({GntA, GntB}), 16'h0);
    check("release_hold", disp_word(), 16'hBEEF);
    step();
    check("idle_hold", disp_word(), 16'hBEEF);
    ReqB = 1'b1;
    step();
    check("b_after_idle", 16'({GntA, GntB}), 16'h1);

    // Reset mid-ownership, then the next tie goes to A.
    do_reset();
    ReqA = 1'b1; ReqB = 1'b0;
    step();
    ReqB = 1'b1;
    step();
    Reset = 1'b1;
    step();
    check("mid_rst_gnt", 16'({GntA, GntB}), 16'h0);
    check("mid_rst_digits", disp_word(), 16'h0000);
    Reset = 1'b0;
    step();
    check("tie_after_rst", 16'({GntA, GntB}), 16'h2);

    // Owner drops exactly on the expiry cycle while B waits: no IDLE gap.
    do_reset();
    ReqA = 1'b1; ReqB = 1'b0;
    step();
    ReqB = 1'b1;
    step(); step(); step();
    ReqA = 1'b0;
    step();
    check("expiry_handover", 16'({GntA, GntB}), 16'h1);

    // Randomized traffic with sticky requests and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) ReqA = ~ReqA;
      if ($urandom_range(3) == 0) ReqB = ~ReqB;
      if ($urandom_range(1) == 0) DigitsA = 16'($urandom);
      if ($urandom_range(1) == 0) DigitsB = 16'($urandom);
      DpA   = 4'($urandom);
      DpB   = 4'($urandom);
      Reset = ($urandom_range(99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
